// File: rtl/clkdiv_multi_if.sv
`default_nettype none
// clkdiv_multi_if: control/status bundle for the multi-channel rate generator.
// master drives enables, half-periods and sync; slave returns square waves and ticks.
interface clkdiv_multi_if #(
  parameter int CH = 4,
  parameter int W  = 20
);
  logic [CH-1:0]   en;
  logic [CH*W-1:0] half;
  logic            sync;
  logic [CH-1:0]   out;
  logic [CH-1:0]   tick;

  modport master (output en, half, sync, input out, tick);
  modport slave  (input en, half, sync, output out, tick);
endinterface
`default_nettype wire

// File: rtl/clkdiv_multi.sv
`default_nettype none
// clkdiv_multi: CH independent programmable square-wave/tick generators, one clock domain.
// Define CLKDIV_SYNC_EN to make the global sync strobe functional; otherwise sync is ignored.
module clkdiv_multi #(
  parameter int CH = 4,
  parameter int W  = 20
) (
  input wire             clk,
  input wire             rst_n,
  clkdiv_multi_if.slave  bus
);

  localparam logic [W-1:0] ONE = W'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] cnt;
    logic [W-1:0] hact;
    logic [W-1:0] half_i;
    logic         out_q;
    logic         tick_q;

    assign half_i = bus.half[i*W +: W];

    // hact is a shadow of half that only moves at toggle edges while running,
    // so a reprogram never cuts the half-period in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        hact   <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end
`ifdef CLKDIV_SYNC_EN
      else if (bus.sync) begin
        cnt    <= '0;
        hact   <= half_i;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end
`endif
      else if (!bus.en[i]) begin
        hact   <= half_i;
        tick_q <= 1'b0;
      end else if (cnt == hact) begin
        cnt    <= '0;
        hact   <= half_i;
        out_q  <= ~out_q;
        tick_q <= 1'b1;
      end else begin
        cnt    <= cnt + ONE;
        tick_q <= 1'b0;
      end
    end

    assign bus.out[i]  = out_q;
    assign bus.tick[i] = tick_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_multi.sv
`default_nettype none
// tb_clkdiv_multi: directed self-checking bench for clkdiv_multi (CH=4, W=20).
// Expectations follow CLKDIV_SYNC_EN when the sync phase is checked.
module tb_clkdiv_multi;

  localparam int CH = 4;
  localparam int W  = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  clkdiv_multi_if #(.CH(CH), .W(W)) bus ();

  clkdiv_multi #(.CH(CH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_half(input int ch, input logic [W-1:0] v);
    bus.half[ch*W +: W] = v;
  endtask

  int t3[7] = '{0, 0, 1, 0, 1, 0, 1};
  int o3[7] = '{0, 0, 1, 1, 0, 0, 1};

  initial begin
    bus.en   = '0;
    bus.half = '0;
    bus.sync = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", 32'(bus.out), 0);
    check("rst_tick", 32'(bus.tick), 0);
    #19 rst_n = 1'b1;

    set_half(0, 3);
    set_half(1, 0);
    set_half(2, 4);
    set_half(3, 2);
    step();                       // disabled edge loads hact
    bus.en = 4'b0011;

    // Basic period (ch0, half=3) and minimum divide (ch1, half=0)
    for (int k = 1; k <= 8; k++) begin
      step();
      check("p_out0", 32'(bus.out[0]), 32'((k / 4) % 2));
      check("p_tick0", 32'(bus.tick[0]), 32'(k % 4 == 0));
      check("p_out1", 32'(bus.out[1]), 32'(k % 2));
      check("p_tick1", 32'(bus.tick[1]), 1);
    end

    // Glitch-free reprogram at cnt=1
    step();
    set_half(0, 1);
    for (int k = 0; k < 7; k++) begin
      step();
      check("rp_tick0", 32'(bus.tick[0]), 32'(t3[k]));
      check("rp_out0", 32'(bus.out[0]), 32'(o3[k]));
    end
    bus.en = 4'b0000;

    // Enable pause on ch2 (half=4) at cnt=2
    bus.en[2] = 1'b1;
    step();
    step();
    bus.en[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("pz_out2", 32'(bus.out[2]), 0);
      check("pz_tick2", 32'(bus.tick[2]), 0);
    end
    bus.en[2] = 1'b1;
    step();
    check("rs1_tick2", 32'(bus.tick[2]), 0);
    step();
    check("rs2_tick2", 32'(bus.tick[2]), 0);
    step();
    check("rs3_tick2", 32'(bus.tick[2]), 1);
    check("rs3_out2", 32'(bus.out[2]), 1);
    bus.en[2] = 1'b0;

    // Sync alignment: ch0 and ch3 at half=2, one edge apart
    set_half(0, 2);
    set_half(3, 2);
    step();
    bus.en = 4'b1000;
    step();
    bus.en = 4'b1001;
    step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
`ifdef CLKDIV_SYNC_EN
    check("sy_a3_out", 32'({bus.out[3], bus.out[2], bus.out[0]}), 32'(3'b000));
    check("sy_a3_tick", 32'({bus.tick[3], bus.tick[0]}), 32'(2'b00));
`else
    check("sy_a3_out", 32'({bus.out[3], bus.out[2], bus.out[0]}), 32'(3'b111));
    check("sy_a3_tick", 32'({bus.tick[3], bus.tick[0]}), 32'(2'b10));
`endif
    step();
    step();
    step();
`ifdef CLKDIV_SYNC_EN
    check("sy_a6_out", 32'({bus.out[3], bus.out[0]}), 32'(2'b11));
    check("sy_a6_tick", 32'({bus.tick[3], bus.tick[0]}), 32'(2'b11));
`else
    check("sy_a6_out", 32'({bus.out[3], bus.out[0]}), 32'(2'b00));
    check("sy_a6_tick", 32'({bus.tick[3], bus.tick[0]}), 32'(2'b10));
`endif

    // Asynchronous reset mid-operation
    bus.en = 4'b1111;
    step();
    step();
    step();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("ar_out", 32'(bus.out), 0);
    check("ar_tick", 32'(bus.tick), 0);
    #4 rst_n = 1'b1;
    step();
    check("ar_e1_out", 32'(bus.out), 32'(4'b1111));
    check("ar_e1_tick", 32'(bus.tick), 32'(4'b1111));
    step();
    check("ar_e2_tick", 32'(bus.tick), 32'(4'b0010));
    check("ar_e2_out", 32'(bus.out), 32'(4'b1101));
    step();
    check("ar_e3_tick", 32'(bus.tick), 32'(4'b0010));
    step();
    check("ar_e4_tick", 32'(bus.tick), 32'(4'b1011));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
